// File: rtl/heap_root_node_pkg.sv
// Shared definitions for the heap root stage: FSM encoding and child-select codes.
package heap_root_node_pkg;

    // Root-stage sequencing states.
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_CMP  = 2'd3
    } state_t;

    // Level-1 child selectors; these double as the level-1 RAM addresses.
    localparam logic CHILD_L = 1'b0;
    localparam logic CHILD_R = 1'b1;

endpackage

// File: rtl/heap_root_node_if.sv
// Key stream, popped-minimum stream and level-1 RAM/handshake signals of the root stage.
interface heap_root_node_if #(
    parameter int WIDTH = 15
);
    logic [WIDTH:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic           flush;
    logic [WIDTH:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic [WIDTH:0] q_A;
    logic [WIDTH:0] q_B;
    logic           addr_A;
    logic           addr_B;
    logic [WIDTH:0] data_A;
    logic [WIDTH:0] data_B;
    logic           wren_A;
    logic           wren_B;
    logic           initialize;
    logic           update_out;
    logic           address_updated_out;
    logic           busy_in;

    // The root stage itself.
    modport slave (
        input  in_data, in_valid, flush, out_ready, q_A, q_B, busy_in,
        output in_ready, out_data, out_valid, addr_A, addr_B, data_A, data_B,
               wren_A, wren_B, initialize, update_out, address_updated_out
    );

    // The surroundings: key producer, output consumer and level 1.
    modport master (
        output in_data, in_valid, flush, out_ready, q_A, q_B, busy_in,
        input  in_ready, out_data, out_valid, addr_A, addr_B, data_A, data_B,
               wren_A, wren_B, initialize, update_out, address_updated_out
    );

endinterface

// File: rtl/heap_root_node.sv
// Root (level 0) of the pipelined min-heap sorter: push-pop against the root register,
// then one sift step of the old root into the level-1 children.
module heap_root_node
    import heap_root_node_pkg::*;
#(
    parameter int WIDTH  = 15,
    parameter int RD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    heap_root_node_if.slave bus
);

    localparam logic [WIDTH:0]   SENTINEL = {(WIDTH + 1){1'b1}};
    localparam int               CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    state_t           state_reg, state_next;
    logic [WIDTH:0]   root_reg, root_next;
    logic [WIDTH:0]   out_data_reg, out_data_next;
    logic             out_valid_reg, out_valid_next;
    logic             in_ready_reg, in_ready_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [1:0]       wren_reg, wren_next;
    logic             initialize_reg, initialize_next;
    logic             update_reg, update_next;
    logic             child_reg, child_next;

    logic [WIDTH:0]   q [2];
    logic [WIDTH:0]   wr_value;
    logic [WIDTH:0]   key;
    logic [WIDTH:0]   pop;
    logic [WIDTH:0]   min_child;
    logic             min_sel;
    logic             accept;
    logic             in_ready;

    assign q[0] = bus.q_A;
    assign q[1] = bus.q_B;

    // The state-dependent part of ready is registered a cycle ahead; the output-stall and
    // level-1 busy terms are applied live so a retiring output and a new key can share a cycle.
    assign in_ready = in_ready_reg && !bus.busy_in && (!out_valid_reg || bus.out_ready);

    // Next-state, root update, output register and level-1 write decisions.
    always_comb begin
        state_next      = state_reg;
        root_next       = root_reg;
        out_data_next   = out_data_reg;
        out_valid_next  = out_valid_reg;
        wait_cnt_next   = wait_cnt_reg;
        wren_next       = 2'b00;
        wr_value        = root_reg;
        initialize_next = 1'b0;
        update_next     = 1'b0;
        child_next      = CHILD_L;
        accept          = 1'b0;
        pop             = root_reg;
        key             = bus.in_valid ? bus.in_data : SENTINEL;
        min_sel         = (q[0] <= q[1]) ? CHILD_L : CHILD_R;
        min_child       = q[min_sel];

        if (out_valid_reg && bus.out_ready) begin
            out_valid_next = 1'b0;
        end

        unique case (state_reg)
            ST_INIT: begin
                wren_next       = 2'b11;
                wr_value        = SENTINEL;
                initialize_next = 1'b1;
                root_next       = SENTINEL;
                state_next      = ST_IDLE;
            end
            ST_IDLE: begin
                accept = in_ready && (bus.in_valid || bus.flush);
                if (accept) begin
                    // A SENTINEL root is an empty slot: any key moves in rather than passing by.
                    if ((key <= root_reg) && (root_reg != SENTINEL)) begin
                        pop = key;
                    end else begin
                        pop           = root_reg;
                        root_next     = key;
                        wait_cnt_next = '0;
                        state_next    = ST_WAIT;
                    end
                    out_data_next  = pop;
                    out_valid_next = (pop != SENTINEL);
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == CNT_LAST) begin
                    state_next = ST_CMP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            ST_CMP: begin
                state_next = ST_IDLE;
                // Strictly smaller only: equal values (including SENTINEL pairs) never move.
                if (min_child < root_reg) begin
                    wren_next[min_sel] = 1'b1;
                    wr_value           = root_reg;
                    root_next          = min_child;
                    update_next        = 1'b1;
                    child_next         = min_sel;
                end
            end
            default: state_next = ST_INIT;
        endcase

        in_ready_next = (state_next == ST_IDLE) && (state_reg != ST_INIT) && !update_next;
    end

    // State, root and single-cycle handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_INIT;
            root_reg       <= SENTINEL;
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            in_ready_reg   <= 1'b0;
            wait_cnt_reg   <= '0;
            wren_reg       <= 2'b00;
            initialize_reg <= 1'b0;
            update_reg     <= 1'b0;
            child_reg      <= CHILD_L;
        end else begin
            state_reg      <= state_next;
            root_reg       <= root_next;
            out_data_reg   <= out_data_next;
            out_valid_reg  <= out_valid_next;
            in_ready_reg   <= in_ready_next;
            wait_cnt_reg   <= wait_cnt_next;
            wren_reg       <= wren_next;
            initialize_reg <= initialize_next;
            update_reg     <= update_next;
            child_reg      <= child_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_child
            logic [WIDTH:0] data_reg;
            // Write data for this child; it only changes when a write to it is issued.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (wren_next[gi]) begin
                    data_reg <= wr_value;
                end
            end
        end
    endgenerate

    assign bus.in_ready            = in_ready;
    assign bus.out_data            = out_data_reg;
    assign bus.out_valid           = out_valid_reg;
    assign bus.addr_A              = CHILD_L;
    assign bus.addr_B              = CHILD_R;
    assign bus.data_A              = g_child[0].data_reg;
    assign bus.data_B              = g_child[1].data_reg;
    assign bus.wren_A              = wren_reg[0];
    assign bus.wren_B              = wren_reg[1];
    assign bus.initialize          = initialize_reg;
    assign bus.update_out          = update_reg;
    assign bus.address_updated_out = child_reg;

endmodule

// File: tb/tb_heap_root_node.sv
// Self-checking bench for heap_root_node: reset/INIT, directed push-pop table, stall,
// busy and reset-abort sequences, then randomized keys against a behavioural model.
module tb_heap_root_node;

    localparam int         W      = 15;
    localparam int         RD_LAT = 2;
    localparam logic [W:0] SENT   = 16'hFFFF;

    typedef struct {
        logic [W:0] key;
        logic       fl;
        logic [W:0] qa;
        logic [W:0] qb;
        logic       ev;
        logic [W:0] eo;
        logic       ewa;
        logic       ewb;
        logic [W:0] ed;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         checks = 0;
    int         errors = 0;
    logic [W:0] ram [2];
    logic [W:0] m_root;
    vec_t       tbl [14];

    heap_root_node_if #(.WIDTH(W)) bus ();

    heap_root_node #(.WIDTH(W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Level-1 RAM contents as seen by the root (bench-owned).
    assign bus.q_A = ram[0];
    assign bus.q_B = ram[1];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One key (or flush) through the root, observing the pop and the sift window.
    task automatic run_txn(input logic [W:0] key, input logic fl,
                           output logic gv, output logic [W:0] go,
                           output logic gwa, output logic gwb, output logic [W:0] gd,
                           output logic gu, output logic gad, output logic gs);
        int n;
        gwa = 1'b0; gwb = 1'b0; gd = '0; gu = 1'b0; gad = 1'b0; gs = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", bus.in_ready, 1'b1);
        if (fl) begin
            bus.in_valid = 1'b0;
            bus.flush    = 1'b1;
        end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = key;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        gv = bus.out_valid;
        go = bus.out_data;
        for (int k = 2; k <= RD_LAT + 3; k++) begin
            @(negedge clk);
            if (k == RD_LAT + 2) begin
                gwa = bus.wren_A;
                gwb = bus.wren_B;
                gd  = bus.wren_B ? bus.data_B : bus.data_A;
                gu  = bus.update_out;
                gad = bus.address_updated_out;
            end else if (bus.wren_A || bus.wren_B || bus.update_out) begin
                gs = 1'b1;
            end
            if (bus.wren_A) ram[0] = bus.data_A;
            if (bus.wren_B) ram[1] = bus.data_B;
        end
    endtask

    task automatic score(input string tag, input logic ev, input logic [W:0] eo,
                         input logic ewa, input logic ewb, input logic [W:0] ed,
                         input logic gv, input logic [W:0] go, input logic gwa,
                         input logic gwb, input logic [W:0] gd, input logic gu,
                         input logic gad, input logic gs);
        check({tag, "_out_valid"}, gv, ev);
        if (ev) check({tag, "_out_data"}, go, eo);
        check({tag, "_wren_A"}, gwa, ewa);
        check({tag, "_wren_B"}, gwb, ewb);
        if (ewa || ewb) begin
            check({tag, "_wdata"}, gd, ed);
            check({tag, "_addr_upd"}, gad, ewb);
        end
        check({tag, "_update_out"}, gu, ewa | ewb);
        check({tag, "_stray"}, gs, 1'b0);
    endtask

    initial begin
        logic       gv, gwa, gwb, gu, gad, gs, fl, e_valid, e_wa, e_wb, stale;
        logic [W:0] go, gd, key, mk, e_out, e_data;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.busy_in   = 1'b0;
        ram[0] = SENT;
        ram[1] = SENT;

        // Directed push-pop vectors, applied in order from an empty heap.
        tbl[0]  = '{16'd5,  1'b0, SENT,   SENT,   1'b0, 16'd0,  1'b0, 1'b0, 16'd0};
        tbl[1]  = '{16'd9,  1'b0, 16'd7,  16'd9,  1'b1, 16'd5,  1'b1, 1'b0, 16'd9};
        tbl[2]  = '{16'd8,  1'b0, 16'd4,  16'd9,  1'b1, 16'd7,  1'b1, 1'b0, 16'd8};
        tbl[3]  = '{16'd2,  1'b0, 16'd7,  16'd9,  1'b1, 16'd2,  1'b0, 1'b0, 16'd0};
        tbl[4]  = '{16'd8,  1'b0, 16'd7,  16'd9,  1'b1, 16'd4,  1'b1, 1'b0, 16'd8};
        tbl[5]  = '{16'd9,  1'b0, 16'd4,  16'd9,  1'b1, 16'd7,  1'b1, 1'b0, 16'd9};
        tbl[6]  = '{16'd10, 1'b0, 16'd6,  16'd6,  1'b1, 16'd4,  1'b1, 1'b0, 16'd10};
        tbl[7]  = '{16'd7,  1'b0, 16'd9,  16'd3,  1'b1, 16'd6,  1'b0, 1'b1, 16'd7};
        tbl[8]  = '{16'd5,  1'b0, 16'd5,  16'd5,  1'b1, 16'd3,  1'b0, 1'b0, 16'd0};
        tbl[9]  = '{16'd5,  1'b0, 16'd5,  16'd5,  1'b1, 16'd5,  1'b0, 1'b0, 16'd0};
        tbl[10] = '{16'd9,  1'b0, 16'd4,  SENT,   1'b1, 16'd5,  1'b1, 1'b0, 16'd9};
        tbl[11] = '{16'd0,  1'b1, 16'd5,  SENT,   1'b1, 16'd4,  1'b1, 1'b0, SENT};
        tbl[12] = '{16'd0,  1'b1, SENT,   SENT,   1'b1, 16'd5,  1'b0, 1'b0, 16'd0};
        tbl[13] = '{16'd0,  1'b1, SENT,   SENT,   1'b0, 16'd0,  1'b0, 1'b0, 16'd0};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wren_A", bus.wren_A, 1'b0);
        check("rst_wren_B", bus.wren_B, 1'b0);
        check("rst_data_A", bus.data_A, 16'd0);
        check("rst_initialize", bus.initialize, 1'b0);
        check("rst_update_out", bus.update_out, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_addr_A", bus.addr_A, 1'b0);
        check("rst_addr_B", bus.addr_B, 1'b1);
        rst = 1'b0;

        // INIT cycle, then ready.
        @(negedge clk);
        check("init_wren_A", bus.wren_A, 1'b1);
        check("init_wren_B", bus.wren_B, 1'b1);
        check("init_data_A", bus.data_A, SENT);
        check("init_data_B", bus.data_B, SENT);
        check("init_initialize", bus.initialize, 1'b1);
        check("init_in_ready", bus.in_ready, 1'b0);
        $display("txn init: wren=%b%b initialize=%b", bus.wren_A, bus.wren_B, bus.initialize);
        @(negedge clk);
        check("post_init_wren", bus.wren_A | bus.wren_B, 1'b0);
        check("post_init_initialize", bus.initialize, 1'b0);
        check("post_init_in_ready", bus.in_ready, 1'b1);

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            ram[0] = tbl[i].qa;
            ram[1] = tbl[i].qb;
            run_txn(tbl[i].key, tbl[i].fl, gv, go, gwa, gwb, gd, gu, gad, gs);
            score($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eo, tbl[i].ewa, tbl[i].ewb,
                  tbl[i].ed, gv, go, gwa, gwb, gd, gu, gad, gs);
            $display("txn vec%0d: key=%h flush=%b out_valid=%b out=%h wren=%b%b data=%h",
                     i, tbl[i].key, tbl[i].fl, gv, go, gwa, gwb, gd);
        end

        // Output stall: root becomes 3, then a bypass pop is held while out_ready=0.
        ram[0] = SENT;
        ram[1] = SENT;
        run_txn(16'd3, 1'b0, gv, go, gwa, gwb, gd, gu, gad, gs);
        check("fill_out_valid", gv, 1'b0);
        bus.out_ready = 1'b0;
        check("stall_pre_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd2;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_out_valid", bus.out_valid, 1'b1);
            check("stall_out_data", bus.out_data, 16'd2);
            check("stall_in_ready", bus.in_ready, 1'b0);
        end
        $display("txn stall: out=%h held with out_ready=0", bus.out_data);
        // Retire and load in the same cycle.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'd1;
        #1;
        check("retire_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("retire_load_valid", bus.out_valid, 1'b1);
        check("retire_load_data", bus.out_data, 16'd1);
        $display("txn retire+load: out=%h", bus.out_data);
        @(negedge clk);
        check("retired_valid", bus.out_valid, 1'b0);

        // Level-1 busy blocks new keys.
        bus.busy_in = 1'b1;
        #1;
        check("busy_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        check("busy_in_ready_hold", bus.in_ready, 1'b0);
        bus.busy_in = 1'b0;
        #1;
        check("busy_release_ready", bus.in_ready, 1'b1);
        $display("txn busy: in_ready released=%b", bus.in_ready);

        // Reset during WAIT aborts the pending sift.
        ram[0] = 16'd1;
        ram[1] = SENT;
        @(negedge clk);
        check("abort_pre_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd10;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("abort_out_data", bus.out_data, 16'd3);
        rst = 1'b1;
        @(negedge clk);
        check("abort_wren", {bus.wren_A, bus.wren_B}, 2'b00);
        check("abort_update_out", bus.update_out, 1'b0);
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_out_data_zero", bus.out_data, 16'd0);
        check("abort_in_ready", bus.in_ready, 1'b0);
        check("abort_initialize", bus.initialize, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("reinit_wren", {bus.wren_A, bus.wren_B}, 2'b11);
        check("reinit_data_A", bus.data_A, SENT);
        check("reinit_initialize", bus.initialize, 1'b1);
        check("reinit_update_out", bus.update_out, 1'b0);
        ram[0] = SENT;
        ram[1] = SENT;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.wren_A || bus.wren_B || bus.update_out) stale = 1'b1;
        end
        check("reinit_no_stale", stale, 1'b0);
        $display("txn reset-abort: reinit done, stale=%b", stale);
        m_root = SENT;

        // Randomized keys against the behavioural model.
        for (int t = 0; t < 40; t++) begin
            ram[0] = ($urandom_range(0, 3) == 0) ? SENT : 16'($urandom_range(0, 20));
            ram[1] = ($urandom_range(0, 3) == 0) ? SENT : 16'($urandom_range(0, 20));
            fl  = ($urandom_range(0, 5) == 0);
            key = 16'($urandom_range(0, 24));
            mk  = fl ? SENT : key;
            e_wa = 1'b0;
            e_wb = 1'b0;
            e_data = '0;
            if (m_root != SENT && mk <= m_root) begin
                e_out = mk;
            end else begin
                e_out  = m_root;
                m_root = mk;
                if (ram[1] < ram[0]) begin
                    if (ram[1] < m_root) begin
                        e_wb = 1'b1;
                        e_data = m_root;
                        m_root = ram[1];
                    end
                end else if (ram[0] < m_root) begin
                    e_wa = 1'b1;
                    e_data = m_root;
                    m_root = ram[0];
                end
            end
            e_valid = (e_out != SENT);
            run_txn(key, fl, gv, go, gwa, gwb, gd, gu, gad, gs);
            score($sformatf("rnd%0d", t), e_valid, e_out, e_wa, e_wb, e_data,
                  gv, go, gwa, gwb, gd, gu, gad, gs);
            $display("txn rnd%0d: key=%h flush=%b out_valid=%b out=%h wren=%b%b data=%h",
                     t, key, fl, gv, go, gwa, gwb, gd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
